seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 4-digit common-anode 7-segment display.
//  Sequences digit select 0->1->2->3->0 and drives active-low anode enables and hex-decoded segments.
//  Inserts an all-off blanking interval between digits to suppress ghosting.
//  Latches display data only at frame boundaries, so a frame never mixes two values (no tearing).
// PARAMETERS
//  TICK_DIV     50000  clk cycles per scan tick; legal >= 2
//  SHOW_TICKS   4      ticks each digit stays lit; legal >= 1
//  BLANK_TICKS  1      ticks all anodes off before each digit; legal >= 1
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  en           in   1   scan enable; 0 = display dark, scanner parked
//  value        in   16  four hex nibbles; [3:0]=digit0 ... [15:12]=digit3
//  dp_in        in   4   decimal point per digit, 1 = lit
//  an           out  4   anode enables, active-low, one-hot-low while showing
//  seg          out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp           out  1   decimal point, active-low
//  frame_start  out  1   one-cycle pulse when the shadow registers load new data
// BEHAVIOUR
//  - Reset (async, any time): state=BLANK, idx=0, prescaler=0, tick_cnt=0, shadow=0;
//    an=4'b1111, seg=7'b1111111, dp=1, frame_start=0. Deassertion is synchronous to clk.
//  - Prescaler: counts 0..TICK_DIV-1 and wraps; tick is asserted in the cycle the count is TICK_DIV-1.
//  - FSM, advanced only on tick:
//    BLANK: tick_cnt counts to BLANK_TICKS-1, then SHOW, tick_cnt=0.
//    SHOW:  tick_cnt counts to SHOW_TICKS-1, then BLANK, tick_cnt=0, idx=idx+1 (3 wraps to 0).
//  - Frame boundary is the SHOW->BLANK transition with idx==3, including the first tick after reset.
//    On that clk edge, value and dp_in load into shadow regs and frame_start pulses high for one
//    cycle. The first BLANK after reset also loads shadow data on its entry tick.
//  - Outputs are registered and follow the state/idx/shadow data with 1 clk of latency:
//    BLANK: an=1111, seg=1111111, dp=1.
//    SHOW:  an[idx]=0 with all other anodes 1; seg=hex7(shadow nibble idx); dp=~shadow_dp[idx].
//  - hex7 (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//    6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001
//    E=0000110 F=0001110.
//  - en=0: synchronously force state=BLANK, idx=0, prescaler=0, tick_cnt=0; outputs go dark on the
//    next edge; frame_start=0. When en rises, the scan restarts from digit 0 with a fresh frame load.
//  - Changes to value mid-frame have no effect until the next frame boundary.
//  - Never more than one anode low; an=0000 is illegal in every state.
// CONFIGURATION
//  LZ_SUPPRESS_EN defined: during SHOW, a digit whose shadow nibble is 0 and all of whose
//    higher-index nibbles are 0 is blanked (seg=1111111, an stays enabled, dp still follows dp_in).
//    Digit 0 is never suppressed. Example: value=16'h0042 shows "  42".
//  LZ_SUPPRESS_EN undefined: all four digits always display; 16'h0042 shows "0042".
// TESTING (sim: TICK_DIV=4, SHOW_TICKS=2, BLANK_TICKS=1)
//  1. Assert rst mid-scan, with no clk edge -> an=1111, seg=1111111, dp=1, frame_start=0 immediately.
//  2. en=1, value=16'h3210, dp_in=0 -> repeating an sequence 1111,1110,1111,1101,1111,1011,1111,0111;
//     each lit phase lasts 8 clks and each blank phase 4 clks; seg is 1000000,1111001,0100100,0110000.
//  3. Change value to 16'hFEDC while digit 1 is lit -> digits 2 and 3 still show 2 and 3; after
//     frame_start pulses, digit 0 shows seg=1000110.
//  4. dp_in=4'b0100 -> dp=0 only while an=1011; dp=1 in all other phases.
//  5. Drop en for 3 clks mid-digit 2 -> an=1111 one clk later; after en returns, digit 0 is lit first
//     and frame_start pulses once.
//  6. LZ_SUPPRESS_EN with value=16'h0042 -> digits 3 and 2 have seg=1111111 and digit 1 shows 4;
//     with value=16'h0000, only digit 0 shows 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Digits are visited 0->1->2->3->0. Each digit is preceded by an
// all-off blanking interval that suppresses ghosting. Display data is copied
// into shadow registers only at frame boundaries, so one frame never mixes
// two different values.
//
// Optional feature macro: LZ_SUPPRESS_EN
//   defined   : leading-zero digits (index 1..3) are blanked while shown
//   undefined : all four digits always display
//
// Parameters
//   TICK_DIV    clk cycles per scan tick (>= 2)
//   SHOW_TICKS  ticks each digit stays lit (>= 1)
//   BLANK_TICKS ticks all anodes stay off before each digit (>= 1)
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   en          scan enable; 0 parks the scanner and darkens the display
//   value[15:0] four hex nibbles, [3:0] = digit 0 ... [15:12] = digit 3
//   dp_in[3:0]  decimal point per digit, 1 = lit
//   an[3:0]     anode enables, active-low
//   seg[6:0]    segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_start one-cycle pulse when the shadow registers load new data
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int TICK_DIV    = 50000,
    parameter int SHOW_TICKS  = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int TMAX = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ZERO   = PW'(0);
    localparam logic [PW-1:0] PRE_ONE    = PW'(1);
    localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0] TCNT_ZERO  = TW'(0);
    localparam logic [TW-1:0] TCNT_ONE   = TW'(1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [PW-1:0] r_pre;
    logic [TW-1:0] r_tcnt;
    logic [15:0]   r_shadow_val;
    logic [3:0]    r_shadow_dp;
    // Set after reset or disable: the next tick must start a fresh frame.
    logic          r_load_pend;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_start;

    logic          w_tick;
    logic [3:0]    w_nib;
    logic          w_lz;
    logic [3:0]    w_an_nx;
    logic [6:0]    w_seg_nx;
    logic          w_dp_nx;

    // Tick decode, digit selection and next output pattern from current state.
    always_comb begin
        w_tick   = (r_pre == PRE_LAST);
        w_nib    = 4'h0;
        w_lz     = 1'b0;
        w_an_nx  = 4'b1111;
        w_seg_nx = 7'b1111111;
        w_dp_nx  = 1'b1;

        case (r_idx)
            2'd0:    w_nib = r_shadow_val[3:0];
            2'd1:    w_nib = r_shadow_val[7:4];
            2'd2:    w_nib = r_shadow_val[11:8];
            2'd3:    w_nib = r_shadow_val[15:12];
            default: w_nib = 4'h0;
        endcase

`ifdef LZ_SUPPRESS_EN
        // A digit is a leading zero when it and every higher digit are zero;
        // digit 0 always shows so a zero value still reads "0".
        case (r_idx)
            2'd3:    w_lz = (r_shadow_val[15:12] == 4'h0);
            2'd2:    w_lz = (r_shadow_val[15:8] == 8'h00);
            2'd1:    w_lz = (r_shadow_val[15:4] == 12'h000);
            default: w_lz = 1'b0;
        endcase
`else
        w_lz = 1'b0;
`endif

        if (r_state == ST_SHOW) begin
            case (r_idx)
                2'd0:    w_an_nx = 4'b1110;
                2'd1:    w_an_nx = 4'b1101;
                2'd2:    w_an_nx = 4'b1011;
                2'd3:    w_an_nx = 4'b0111;
                default: w_an_nx = 4'b1111;
            endcase
            if (w_lz) begin
                w_seg_nx = 7'b1111111;
            end else begin
                w_seg_nx = hex7(w_nib);
            end
            w_dp_nx = ~r_shadow_dp[r_idx];
        end else begin
            w_an_nx  = 4'b1111;
            w_seg_nx = 7'b1111111;
            w_dp_nx  = 1'b1;
        end
    end

    // Prescaler, scan FSM, frame-boundary shadow load and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BLANK;
            r_idx         <= 2'd0;
            r_pre         <= PRE_ZERO;
            r_tcnt        <= TCNT_ZERO;
            r_shadow_val  <= 16'h0000;
            r_shadow_dp   <= 4'b0000;
            r_load_pend   <= 1'b1;
            r_an          <= 4'b1111;
            r_seg         <= 7'b1111111;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (!en) begin
            // Parked: restart from digit 0 with a fresh frame once enabled.
            r_state       <= ST_BLANK;
            r_idx         <= 2'd0;
            r_pre         <= PRE_ZERO;
            r_tcnt        <= TCNT_ZERO;
            r_load_pend   <= 1'b1;
            r_an          <= 4'b1111;
            r_seg         <= 7'b1111111;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_an          <= w_an_nx;
            r_seg         <= w_seg_nx;
            r_dp          <= w_dp_nx;
            r_frame_start <= 1'b0;

            if (w_tick) begin
                r_pre <= PRE_ZERO;
            end else begin
                r_pre <= r_pre + PRE_ONE;
            end

            if (w_tick) begin
                case (r_state)
                    ST_BLANK: begin
                        if (r_load_pend) begin
                            r_shadow_val  <= value;
                            r_shadow_dp   <= dp_in;
                            r_frame_start <= 1'b1;
                            r_load_pend   <= 1'b0;
                        end
                        if (r_tcnt == BLANK_LAST) begin
                            r_state <= ST_SHOW;
                            r_tcnt  <= TCNT_ZERO;
                        end else begin
                            r_tcnt <= r_tcnt + TCNT_ONE;
                        end
                    end
                    ST_SHOW: begin
                        if (r_tcnt == SHOW_LAST) begin
                            r_state <= ST_BLANK;
                            r_tcnt  <= TCNT_ZERO;
                            r_idx   <= r_idx + 2'd1;
                            // Leaving digit 3 closes the frame.
                            if (r_idx == 2'd3) begin
                                r_shadow_val  <= value;
                                r_shadow_dp   <= dp_in;
                                r_frame_start <= 1'b1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + TCNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_BLANK;
                        r_tcnt  <= TCNT_ZERO;
                        r_idx   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=4, SHOW_TICKS=2,
// BLANK_TICKS=1. Edge numbers below count rising clk edges since the last
// reset release; digit d (frame-relative) is lit on edges 5+12d .. 12+12d.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int total;
    int bad;
    int cur;

    seg_scan_ctrl #(
        .TICK_DIV   (4),
        .SHOW_TICKS (2),
        .BLANK_TICKS(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .value      (value),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, act, exp);
        end
    endtask

    // Check all four outputs at once.
    task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic e_fs);
        chk({tag, ".an"},  {12'd0, an},          {12'd0, e_an});
        chk({tag, ".seg"}, {9'd0, seg},          {9'd0, e_seg});
        chk({tag, ".dp"},  {15'd0, dp},          {15'd0, e_dp});
        chk({tag, ".fs"},  {15'd0, frame_start}, {15'd0, e_fs});
    endtask

    // Advance to the falling edge after rising edge k.
    task automatic go(input int k);
        repeat (k - cur) @(negedge clk);
        cur = k;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cur   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        value = 16'h0000;
        dp_in = 4'b0000;
        #2;
        chk_out("reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);

        // Release reset and start scanning 3210.
        @(negedge clk);
        rst   = 1'b0;
        en    = 1'b1;
        value = 16'h3210;
        cur   = 0;

        go(3);  chk_out("pre_tick", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        go(4);  chk_out("first_load", 4'b1111, 7'b1111111, 1'b1, 1'b1);
        go(5);  chk_out("d0_start", 4'b1110, 7'b1000000, 1'b1, 1'b0);
        go(12); chk_out("d0_end", 4'b1110, 7'b1000000, 1'b1, 1'b0);
        go(13); chk_out("blank1_start", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        go(16); chk_out("blank1_end", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        go(17); chk_out("d1_start", 4'b1101, 7'b1111001, 1'b1, 1'b0);

        // New value and dp mid-frame must not tear the current frame.
        go(18);
        value = 16'hFEDC;
        dp_in = 4'b0100;
        go(29); chk_out("d2_old", 4'b1011, 7'b0100100, 1'b1, 1'b0);
        go(41); chk_out("d3_old", 4'b0111, 7'b0110000, 1'b1, 1'b0);
        go(48); chk_out("frame2_load", 4'b0111, 7'b0110000, 1'b1, 1'b1);
        go(49); chk_out("frame2_blank", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        go(53); chk_out("d0_new", 4'b1110, 7'b1000110, 1'b1, 1'b0);
        go(65); chk_out("d1_new", 4'b1101, 7'b0100001, 1'b1, 1'b0);
        go(77); chk_out("d2_dp", 4'b1011, 7'b0000110, 1'b0, 1'b0);
        go(80); chk_out("d2_dp_late", 4'b1011, 7'b0000110, 1'b0, 1'b0);

        // Disable for three clocks mid-digit 2.
        en = 1'b0;
        go(81); chk_out("en_off", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        go(83);
        en = 1'b1;
        go(86); chk_out("en_back_wait", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        go(87); chk_out("en_back_load", 4'b1111, 7'b1111111, 1'b1, 1'b1);
        go(88); chk_out("en_back_d0", 4'b1110, 7'b1000110, 1'b1, 1'b0);
        go(90);

        // Reset mid-scan between edges: outputs must go dark without a clk edge.
        #1;
        rst = 1'b1;
        #1;
        chk_out("async_reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);

        // Leading-zero behaviour on 0042.
        @(negedge clk);
        rst   = 1'b0;
        en    = 1'b1;
        value = 16'h0042;
        dp_in = 4'b0000;
        cur   = 0;
        go(5);  chk_out("lz_d0", 4'b1110, 7'b0100100, 1'b1, 1'b0);
        go(17); chk_out("lz_d1", 4'b1101, 7'b0011001, 1'b1, 1'b0);
`ifdef LZ_SUPPRESS_EN
        go(29); chk_out("lz_d2", 4'b1011, 7'b1111111, 1'b1, 1'b0);
        go(41); chk_out("lz_d3", 4'b0111, 7'b1111111, 1'b1, 1'b0);
`else
        go(29); chk_out("lz_d2", 4'b1011, 7'b1000000, 1'b1, 1'b0);
        go(41); chk_out("lz_d3", 4'b0111, 7'b1000000, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
